// File: rtl/aes_key_pkg.sv
// Shared AES key-schedule definitions: mode encodings, Nk/Nr lookups, rcon table, widths.
package aes_key_pkg;

  localparam int WORD_W = 32;
  localparam int RK_W   = 128;
  localparam int IDX_W  = 6;

  typedef enum logic [1:0] {
    MODE_128 = 2'd0,
    MODE_192 = 2'd1,
    MODE_256 = 2'd2,
    MODE_RSV = 2'd3
  } aes_mode_e;

  function automatic logic [3:0] nk_of(input logic [1:0] m);
    case (m)
      MODE_128: return 4'd4;
      MODE_192: return 4'd6;
      default:  return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] m);
    case (m)
      MODE_128: return 4'd10;
      MODE_192: return 4'd12;
      default:  return 4'd14;
    endcase
  endfunction

  // 4*(Nr+1) words in the full schedule
  function automatic logic [IDX_W-1:0] total_words(input logic [1:0] m);
    case (m)
      MODE_128: return 6'd44;
      MODE_192: return 6'd52;
      default:  return 6'd60;
    endcase
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_subword.sv
// 32-bit SubWord: one S-box lane per byte, shareable with the cipher datapath.
module aes_subword #(
  parameter int NUM_LANES = 4,
  parameter int VEC_W     = 8
) (
  input  logic [NUM_LANES*VEC_W-1:0] a,
  output logic [NUM_LANES*VEC_W-1:0] c
);

  logic [NUM_LANES-1:0][VEC_W-1:0] lane_in, lane_out;

  assign lane_in = a;
  assign c       = lane_out;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    ensbox u_sbox (.a(lane_in[l]), .c(lane_out[l]));
  end

endmodule

// File: rtl/ensbox.sv
// AES forward S-box: GF(2^8) inverse (x^254) followed by the affine transform.
module ensbox (
  input  logic [7:0] a,
  output logic [7:0] c
);

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, s;
    p = '0;
    s = x;
    for (int b = 0; b < 8; b++) begin
      if (y[b]) p = p ^ s;
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] inv, sq;

  // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as AES requires
  always_comb begin
    inv = 8'h01;
    sq  = a;
    for (int k = 0; k < 7; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
  end

  assign c = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
           ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Word-serial AES-128/192/256 key expansion into a word store with a registered round-key read port.
module aes_key_schedule_seq
  import aes_key_pkg::*;
#(
  parameter int KEY_W     = 256,
  parameter int MAX_WORDS = 60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             done,
  output logic             key_valid,
  output logic             cfg_err,
  input  logic [3:0]       rd_round,
  output logic [RK_W-1:0]  rd_key
);

  localparam int KEY_WORDS = KEY_W / WORD_W;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_EXPAND} state_e;

  state_e             state_q, state_d;
  logic [1:0]         mode_q;
  logic [KEY_W-1:0]   key_q;
  logic [IDX_W-1:0]   idx_q;
  logic [2:0]         phase_q;   // i mod Nk
  logic [3:0]         rc_q;      // i/Nk - 1 once phase wraps
  logic [WORD_W-1:0]  w [MAX_WORDS];

  logic [3:0]         nk;
  logic [IDX_W-1:0]   nk6;
  logic               last, mode_ok, idle, accept, reject;
  logic [WORD_W-1:0]  prev, back, sub_in, sub_out, temp, new_word;
  logic [IDX_W-1:0]   rbase;

  assign nk      = nk_of(mode_q);
  assign nk6     = {2'b00, nk};
  assign last    = (idx_q == total_words(mode_q) - 6'd1);
  assign idle    = (state_q == ST_IDLE);
  assign mode_ok = (mode != MODE_RSV) && (WORD_W * int'(nk_of(mode)) <= KEY_W);
  assign accept  = start && idle && mode_ok;
  assign reject  = start && idle && !mode_ok;
  assign busy    = !idle;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_EXPAND;
      ST_EXPAND: if (last) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Single S-box bank: rotated input on the rcon step, straight input on the Nk=8 mid-word step
  assign prev   = w[idx_q - 6'd1];
  assign back   = w[idx_q - nk6];
  assign sub_in = (phase_q == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

  aes_subword u_subword (.a(sub_in), .c(sub_out));

  always_comb begin
    temp = prev;
    if (phase_q == 3'd0)
      temp = sub_out ^ {rcon_of(rc_q), 24'h0};
    else if (nk == 4'd8 && phase_q == 3'd4)
      temp = sub_out;
  end

  assign new_word = back ^ temp;

  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD) begin
      for (int k = 0; k < KEY_WORDS; k++)
        if (k < int'(nk)) w[k] <= key_q[KEY_W-1-WORD_W*k -: WORD_W];
    end else if (state_q == ST_EXPAND) begin
      w[idx_q] <= new_word;
    end
  end

  assign rbase = {rd_round, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_128;
      key_q     <= '0;
      idx_q     <= '0;
      phase_q   <= '0;
      rc_q      <= '0;
      done      <= 1'b0;
      key_valid <= 1'b0;
      cfg_err   <= 1'b0;
      rd_key    <= '0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == ST_EXPAND) && last;
      cfg_err <= reject;
      if (accept) begin
        mode_q    <= mode;
        key_q     <= key_in;
        key_valid <= 1'b0;
      end else if (state_q == ST_EXPAND && last) begin
        key_valid <= 1'b1;
      end
      case (state_q)
        ST_LOAD: begin
          idx_q   <= nk6;
          phase_q <= '0;
          rc_q    <= '0;
        end
        ST_EXPAND: begin
          idx_q   <= idx_q + 6'd1;
          phase_q <= ({1'b0, phase_q} == nk - 4'd1) ? 3'd0 : phase_q + 3'd1;
          if (phase_q == 3'd0) rc_q <= rc_q + 4'd1;
        end
        default: ;
      endcase
      if (key_valid && rd_round <= nr_of(mode_q))
        rd_key <= {w[rbase], w[rbase + 6'd1], w[rbase + 6'd2], w[rbase + 6'd3]};
      else
        rd_key <= '0;
    end
  end

endmodule
